// File: rtl/eight_mux_pkg.sv
// Shared constants and types for the eight_mux datapath selector.
// No logic, so no latency.
// No handshake, so no backpressure.
package eight_mux_pkg;

   localparam int NUM_INPUTS = 8;
   localparam int SEL_W      = 3;

   typedef logic [SEL_W-1:0] sel_t;

endpackage : eight_mux_pkg

// File: rtl/eight_mux_if.sv
// Groups the request side (valid, eight data words, select) and the result side of eight_mux.
// Latency is set by the modules that use it.
// No backpressure: there is no ready signal, and the consumer must take every result.
interface eight_mux_if
   import eight_mux_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] h;
   sel_t             select;
   logic [WIDTH-1:0] out;
   logic             out_valid;

   // The requester drives the data and select, and receives the registered result.
   modport master (
      output in_valid, a, b, c, d, e, f, g, h, select,
      input  out, out_valid
   );

   // The selector receives the data and select, and drives the registered result.
   modport slave (
      input  in_valid, a, b, c, d, e, f, g, h, select,
      output out, out_valid
   );

endinterface : eight_mux_if

// File: rtl/eight_mux_mux2.sv
// 2:1 word selector. This is the leaf cell of the eight_mux tree.
// Purely combinational, so it adds no cycles.
// No backpressure.
module mux2 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   // Pass d1 when s is set; otherwise pass d0.
   always_comb begin
      y = s ? d1 : d0;
   end

endmodule : mux2

// File: rtl/eight_mux.sv
// Registered 8:1 word selector: out takes input[select] on each accepted in_valid.
// Latency is 1 cycle from the sampling edge to out and out_valid.
// No backpressure: a new result is produced every cycle that in_valid is high.
module eight_mux
   import eight_mux_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   eight_mux_if.slave bus
);

   sel_t             sel;
   logic [WIDTH-1:0] l1_ab;
   logic [WIDTH-1:0] l1_cd;
   logic [WIDTH-1:0] l1_ef;
   logic [WIDTH-1:0] l1_gh;
   logic [WIDTH-1:0] l2_ad;
   logic [WIDTH-1:0] l2_eh;
   logic [WIDTH-1:0] sel_word;
   logic [WIDTH-1:0] out_q;
   logic             out_valid_q;

   assign sel = bus.select;

   // Level 1, steered by select[0]: picks within each adjacent pair.
   mux2 #(.WIDTH(WIDTH)) u_l1_ab (.d0(bus.a), .d1(bus.b), .s(sel[0]), .y(l1_ab));
   mux2 #(.WIDTH(WIDTH)) u_l1_cd (.d0(bus.c), .d1(bus.d), .s(sel[0]), .y(l1_cd));
   mux2 #(.WIDTH(WIDTH)) u_l1_ef (.d0(bus.e), .d1(bus.f), .s(sel[0]), .y(l1_ef));
   mux2 #(.WIDTH(WIDTH)) u_l1_gh (.d0(bus.g), .d1(bus.h), .s(sel[0]), .y(l1_gh));

   // Level 2, steered by select[1]: picks within each half.
   mux2 #(.WIDTH(WIDTH)) u_l2_ad (.d0(l1_ab), .d1(l1_cd), .s(sel[1]), .y(l2_ad));
   mux2 #(.WIDTH(WIDTH)) u_l2_eh (.d0(l1_ef), .d1(l1_gh), .s(sel[1]), .y(l2_eh));

   // Level 3, steered by select[2]: picks between the two halves.
   mux2 #(.WIDTH(WIDTH)) u_l3    (.d0(l2_ad), .d1(l2_eh), .s(sel[2]), .y(sel_word));

   // Capture the selected word on accept and hold it while idle; out_valid pulses once per accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            out_q <= sel_word;
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;

endmodule : eight_mux

// File: tb/tb_eight_mux.sv
// Self-checking bench for eight_mux: directed scenarios plus randomized traffic against a reference model.
// The model predicts out and out_valid one cycle after each sampling edge.
// There is no backpressure to exercise; in_valid is driven freely.
module tb_eight_mux;
   import eight_mux_pkg::*;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   sel_t             sel = '0;
   logic [WIDTH-1:0] w [NUM_INPUTS];

   logic [WIDTH-1:0] exp_out = '0;
   logic             exp_vld = 1'b0;
   int               vectors = 0;
   int               errors  = 0;

   always #5 clk = ~clk;

   eight_mux_if #(.WIDTH(WIDTH)) bus ();

   assign bus.in_valid = in_valid;
   assign bus.select   = sel;
   assign bus.a = w[0];
   assign bus.b = w[1];
   assign bus.c = w[2];
   assign bus.d = w[3];
   assign bus.e = w[4];
   assign bus.f = w[5];
   assign bus.g = w[6];
   assign bus.h = w[7];

   eight_mux #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Advance one clock. The model applies the behavioural rules to the inputs present at the edge.
   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         exp_out = '0;
         exp_vld = 1'b0;
      end else if (in_valid) begin
         exp_out = w[sel];
         exp_vld = 1'b1;
      end else begin
         exp_vld = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NUM_INPUTS; i++) w[i] = WIDTH'(i);
      rst = 1'b1; in_valid = 1'b1; sel = 3'd3;
      for (int i = 0; i < 2; i++) begin
         cycle();
         vectors++;
         if (bus.out !== 32'd0) begin
            errors++; $display("FAIL reset_out cycle %0d: got %h expected 0", i, bus.out);
         end
         vectors++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_vld cycle %0d: got %b expected 0", i, bus.out_valid);
         end
      end
      rst = 1'b0; in_valid = 1'b0; sel = 3'd5;
      cycle();
      vectors++;
      if (bus.out !== 32'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: got out=%h vld=%b expected 0/0", bus.out, bus.out_valid);
      end
      in_valid = 1'b1; sel = 3'd3;
      cycle();
      vectors++;
      if (bus.out !== 32'd3 || bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL first_accept: got out=%h vld=%b expected 3/1", bus.out, bus.out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_sweep();
      for (int i = 0; i < NUM_INPUTS; i++) w[i] = WIDTH'(i);
      in_valid = 1'b1;
      for (int s = 0; s < NUM_INPUTS; s++) begin
         sel = sel_t'(s);
         cycle();
         vectors++;
         if (bus.out !== WIDTH'(s) || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL sweep sel=%0d: got out=%h vld=%b expected %h/1", s, bus.out, bus.out_valid, WIDTH'(s));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_hold();
      for (int i = 0; i < NUM_INPUTS; i++) w[i] = WIDTH'(i);
      in_valid = 1'b1; sel = 3'd6;
      cycle();
      vectors++;
      if (bus.out !== 32'd6 || bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL hold_accept: got out=%h vld=%b expected 6/1", bus.out, bus.out_valid);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sel = sel_t'(i + 1);
         cycle();
         vectors++;
         if (bus.out !== 32'd6 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL hold cycle %0d: got out=%h vld=%b expected 6/0", i, bus.out, bus.out_valid);
         end
      end
   endtask

   task automatic test_full_width();
      logic [2:0]       sels [3];
      logic [WIDTH-1:0] want [3];
      sels[0] = 3'd0; want[0] = 32'hA5A5_5A5A;
      sels[1] = 3'd7; want[1] = 32'hFFFF_FFFF;
      sels[2] = 3'd4; want[2] = 32'h0000_0000;
      for (int i = 0; i < NUM_INPUTS; i++) w[i] = '0;
      w[0] = 32'hA5A5_5A5A;
      w[7] = 32'hFFFF_FFFF;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sel = sels[i];
         cycle();
         vectors++;
         if (bus.out !== want[i] || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL full_width sel=%0d: got out=%h vld=%b expected %h/1", sels[i], bus.out, bus.out_valid, want[i]);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < NUM_INPUTS; i++) w[i] = $urandom() | 32'h1;
      in_valid = 1'b1;
      for (int s = 0; s < 2; s++) begin
         sel = sel_t'(s);
         cycle();
         vectors++;
         if (bus.out !== w[s] || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL midstream_accept sel=%0d: got out=%h vld=%b expected %h/1", s, bus.out, bus.out_valid, w[s]);
         end
      end
      rst = 1'b1; sel = 3'd2;
      cycle();
      vectors++;
      if (bus.out !== 32'd0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL midstream_reset: got out=%h vld=%b expected 0/0", bus.out, bus.out_valid);
      end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < NUM_INPUTS; i++) w[i] = $urandom();
         sel      = sel_t'($urandom_range(NUM_INPUTS - 1, 0));
         in_valid = 1'($urandom_range(1, 0));
         cycle();
         vectors++;
         if (bus.out !== exp_out) begin
            errors++; $display("FAIL random_out n=%0d: got %h expected %h", n, bus.out, exp_out);
         end
         vectors++;
         if (bus.out_valid !== exp_vld) begin
            errors++; $display("FAIL random_vld n=%0d: got %b expected %b", n, bus.out_valid, exp_vld);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_hold();
      test_full_width();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule : tb_eight_mux
